stream_frame_reader: RTL and testbench
======================================

Name: stream_frame_reader

Overview:
- Reads one frame of words from a synchronous-read buffer memory and emits it as an AXI-Stream-style beat sequence with full tready backpressure and tlast on the final beat.
- Sits between the transceiver's frame buffer and the downstream serialiser.
- Runtime base address and frame length; parametrised data/address width and address stride.
- Internal 2-entry output FIFO hides the 1-cycle memory read latency, giving one beat per clock when tready_in is held high.

Parameters:
- ADDR_WIDTH, 4, buffer address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, memory word and tdata width.
- LEN_WIDTH, 4, width of frame length field (max frame 2^LEN_WIDTH-1 beats).
- ADDR_STRIDE, 2, address increment per word read.

Ports:
- clk_in  in  1  single clock, all logic on rising edge.
- rst_n_in  in  1  reset, synchronous, active-low.
- start_in  in  1  frame start request; sampled only in IDLE.
- base_addr_in  in  ADDR_WIDTH  first read address; sampled with start_in.
- frame_len_in  in  LEN_WIDTH  beats in frame; sampled with start_in.
- rd_en_out  out  1  memory read strobe.
- rd_addr_out  out  ADDR_WIDTH  memory read address.
- rd_data_in  in  DATA_WIDTH  memory data, valid 1 clock after the edge capturing rd_en_out/rd_addr_out.
- tdata_out  out  DATA_WIDTH  stream data (FIFO head).
- tvalid_out  out  1  stream valid.
- tlast_out  out  1  high on final beat of frame.
- tready_in  in  1  downstream ready.
- busy_out  out  1  high from start acceptance until the last beat handshakes.
- done_out  out  1  one-clock pulse after last beat handshakes.

Behaviour:
- Reset (rst_n_in=0 at an edge): state IDLE; FIFO empty; in-flight flag cleared; counters 0. Outputs: tvalid_out=0, tlast_out=0, tdata_out=0, rd_en_out=0, rd_addr_out=0, busy_out=0, done_out=0. Reset mid-frame aborts the frame immediately: no further beats, no done_out, and any in-flight read data is discarded.
- FSM states:
  - IDLE: start_in=1 and frame_len_in!=0 -> RUN; latch base/len; busy_out=1. start_in with frame_len_in=0 is ignored (stay IDLE, no done).
  - RUN: issue reads until len reads are issued -> DRAIN.
  - DRAIN: wait for the last beat handshake -> IDLE, done_out=1 for one cycle, busy_out=0.
- start_in is ignored outside IDLE.
- Read issue: rd_en_out=1 in a cycle iff reads_remaining>0 and (fifo_count + inflight - pop) < 2, where pop = tvalid_out & tready_in.
  - rd_addr_out = current address.
  - After each issue, address += ADDR_STRIDE, truncated to ADDR_WIDTH (wraps, e.g. 0xE+2 -> 0x0).
- rd_data_in is written into the FIFO on the clock after the issue edge. Simultaneous push and pop are allowed. The FIFO never overflows; overflow is an assertion failure.
- tvalid_out = FIFO non-empty. tdata_out and tlast_out come from the FIFO head.
- tlast is stored per entry and set for word index len-1.
- While tvalid_out=1 and tready_in=0, tdata_out and tlast_out must hold stable.
- Latency: with tready_in=1, first rd_en_out in the cycle after the start edge (E0); tvalid_out first high after E2. Then one beat per clock, with no bubbles.
- Beat counter counts handshakes. The handshake on the beat with tlast_out=1 ends the frame.
- A new start is accepted in the cycle after done_out (IDLE).

Test Plan:
- Basic frame, tready_in=1: base=0x0, len=5, stride 2 -> rd_addr_out 0,2,4,6,8 on consecutive cycles; 5 beats on consecutive cycles starting E2; tlast_out only on beat 5; done_out pulses once, one cycle after beat 5.
- Address wrap: base=0xC, len=4 -> rd_addr_out 0xC,0xE,0x0,0x2; data matches memory contents at those addresses.
- Backpressure: len=6, tready_in toggling 1,0,0,1,0,1,... -> each beat delivered exactly once in order; tdata/tlast stable across stalls; fifo_count never exceeds 2; rd_en_out suppressed while FIFO + in-flight = 2.
- Zero length and busy start: start with len=0 -> no rd_en_out, no beats, no done. Start pulsed mid-frame with a different base -> ignored; the current frame completes unchanged.
- Reset mid-frame: len=8, assert rst_n_in=0 after beat 3 -> next cycle tvalid_out=0, busy_out=0, rd_en_out=0, no done_out. A new frame after reset starts clean at its own base.
- Back-to-back frames: second start issued the cycle after done_out -> second frame's first tvalid_out appears 2 cycles later; tlast_out is correct for both frames.

Source files
------------

// File: rtl/stream_frame_reader.sv
// Streams one frame of words out of a synchronous-read buffer as valid/ready beats.
// A 2-entry output FIFO absorbs the 1-cycle read latency so a held tready gives one beat per clock.
module stream_frame_reader #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 4,
  parameter int ADDR_STRIDE = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [LEN_WIDTH-1:0]  frame_len_in,
  output logic                  rd_en_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  output logic [DATA_WIDTH-1:0] tdata_out,
  output logic                  tvalid_out,
  output logic                  tlast_out,
  input  logic                  tready_in,
  output logic                  busy_out,
  output logic                  done_out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [LEN_WIDTH-1:0]           reads_rem_q, reads_rem_d;
  logic                           inflight_q, inflight_d;
  logic                           inflight_last_q, inflight_last_d;
  logic [1:0][DATA_WIDTH-1:0]     fifo_data_q, fifo_data_d;
  logic [1:0]                     fifo_last_q, fifo_last_d;
  logic                           wr_ptr_q, wr_ptr_d;
  logic                           rd_ptr_q, rd_ptr_d;
  logic [1:0]                     fifo_count_q, fifo_count_d;
  logic                           done_q, done_d;

  logic       push;
  logic       pop;
  logic       start_ok;
  logic [2:0] occupancy;

  assign tvalid_out  = (fifo_count_q != 2'd0);
  assign tdata_out   = fifo_data_q[rd_ptr_q];
  assign tlast_out   = fifo_last_q[rd_ptr_q];
  assign rd_addr_out = addr_q;
  assign done_out    = done_q;

  assign push      = inflight_q;
  assign pop       = tvalid_out & tready_in;
  assign start_ok  = start_in && (frame_len_in != '0);
  // Words already owed to the FIFO after this cycle's pop; a read is issued only if it still fits.
  assign occupancy = 3'(fifo_count_q) + 3'(inflight_q) - 3'(pop);

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: synchronous reset lives inside the clocked block, and all state uses <= so every
    // flop samples pre-edge values regardless of statement order.
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (rd_en_out && reads_rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
      DRAIN:   if (done_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rd_en_out = 1'b0;
    done_d    = 1'b0;
    busy_out  = (state_q != IDLE);
    if (state_q == RUN && reads_rem_q != '0 && occupancy < 3'd2) rd_en_out = 1'b1;
    if (state_q == DRAIN && pop && tlast_out) done_d = 1'b1;
  end

  // Address generation, read tracking and FIFO bookkeeping.
  always_comb begin
    addr_d          = addr_q;
    reads_rem_d     = reads_rem_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = rd_en_out;
    inflight_last_d = rd_en_out && (reads_rem_q == LEN_WIDTH'(1));
    fifo_count_d    = fifo_count_q + 2'(push) - 2'(pop);

    if (state_q == IDLE && start_ok) begin
      addr_d      = base_addr_in;
      reads_rem_d = frame_len_in;
    end
    if (rd_en_out) begin
      addr_d      = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
      reads_rem_d = reads_rem_q - LEN_WIDTH'(1);
    end
    if (push) begin
      fifo_data_d[wr_ptr_q] = rd_data_in;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      addr_q          <= '0;
      reads_rem_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      // NOTE: the two FIFO entries are reset (unlike a RAM) because the head drives tdata_out,
      // which must read 0 straight out of reset.
      fifo_data_q     <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      fifo_count_q    <= 2'd0;
      done_q          <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      reads_rem_q     <= reads_rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_count_q    <= fifo_count_d;
      done_q          <= done_d;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(push && !pop && fifo_count_q == 2'd2));

endmodule

// File: tb/tb_stream_frame_reader.sv
// Randomised bench for stream_frame_reader: a negedge monitor compares every cycle
// against a frame-level model built from read/beat counts and the memory contents.
module tb_stream_frame_reader;

  localparam int ADDR_WIDTH  = 4;
  localparam int DATA_WIDTH  = 8;
  localparam int LEN_WIDTH   = 4;
  localparam int ADDR_STRIDE = 2;
  localparam int DEPTH       = 1 << ADDR_WIDTH;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in;
  logic                  start_in;
  logic [ADDR_WIDTH-1:0] base_addr_in;
  logic [LEN_WIDTH-1:0]  frame_len_in;
  logic                  rd_en_out;
  logic [ADDR_WIDTH-1:0] rd_addr_out;
  logic [DATA_WIDTH-1:0] rd_data_in;
  logic [DATA_WIDTH-1:0] tdata_out;
  logic                  tvalid_out;
  logic                  tlast_out;
  logic                  tready_in;
  logic                  busy_out;
  logic                  done_out;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference model state, owned by the monitor.
  bit m_busy, m_done_next, d1, d2, pop, accept;
  int m_base, m_len, m_issued, m_delivered, m_arrived;

  stream_frame_reader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .ADDR_STRIDE(ADDR_STRIDE)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .start_in    (start_in),
    .base_addr_in(base_addr_in),
    .frame_len_in(frame_len_in),
    .rd_en_out   (rd_en_out),
    .rd_addr_out (rd_addr_out),
    .rd_data_in  (rd_data_in),
    .tdata_out   (tdata_out),
    .tvalid_out  (tvalid_out),
    .tlast_out   (tlast_out),
    .tready_in   (tready_in),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous-read buffer memory.
  always @(posedge clk_in) if (rd_en_out) rd_data_in <= mem[rd_addr_out];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      m_busy = 0; m_done_next = 0; d1 = 0; d2 = 0;
      m_issued = 0; m_delivered = 0; m_arrived = 0;
    end else begin
      if (d2) m_arrived++;
      pop = tvalid_out && tready_in;
      check("busy", 32'(busy_out), 32'(m_busy));
      check("done", 32'(done_out), 32'(m_done_next));
      check("tvalid", 32'(tvalid_out), 32'(m_arrived > m_delivered));
      check("rd_en", 32'(rd_en_out),
            32'(m_busy && m_issued < m_len && (m_issued - m_delivered - int'(pop)) < 2));
      if (rd_en_out)
        check("rd_addr", 32'(rd_addr_out), 32'((m_base + m_issued * ADDR_STRIDE) % DEPTH));
      if (tvalid_out) begin
        check("tdata", 32'(tdata_out), 32'(mem[(m_base + m_delivered * ADDR_STRIDE) % DEPTH]));
        check("tlast", 32'(tlast_out), 32'(m_delivered == m_len - 1));
      end
      accept = !m_busy && start_in && frame_len_in != '0;
      m_done_next = 0;
      d2 = d1;
      d1 = rd_en_out;
      if (rd_en_out) m_issued++;
      if (pop) begin
        if (m_delivered == m_len - 1) begin
          m_busy = 0;
          m_done_next = 1;
        end
        m_delivered++;
      end
      if (accept) begin
        m_busy = 1; m_base = int'(base_addr_in); m_len = int'(frame_len_in);
        m_issued = 0; m_delivered = 0; m_arrived = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_WIDTH'($urandom);
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b101001;  // bit k is tready in cycle k: 1,0,0,1,0,1
    case (mode)
      0:       return 1'b1;
      1:       return pat[cyc % 6];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_frame(input int base, input int len, input int mode, input bit mid_start);
    bit seen;
    base_addr_in = ADDR_WIDTH'(base);
    frame_len_in = LEN_WIDTH'(len);
    start_in     = 1'b1;
    tready_in    = ready_for(mode, 0);
    step();
    seen = 0;
    for (int cyc = 1; cyc < 200 && !seen; cyc++) begin
      tready_in = ready_for(mode, cyc);
      if (mid_start && cyc == 2) begin
        start_in     = 1'b1;
        base_addr_in = ADDR_WIDTH'(base + 4);
        frame_len_in = LEN_WIDTH'(len + 1);
      end else begin
        start_in = 1'b0;
      end
      step();
      seen = done_out;
    end
    start_in = 1'b0;
    check("frame_done", 32'(seen), 32'(1));
    step();
  endtask

  task automatic zero_len_start(input int base);
    base_addr_in = ADDR_WIDTH'(base);
    frame_len_in = '0;
    start_in     = 1'b1;
    step();
    start_in = 1'b0;
    step();
    check("zero_len_busy", 32'(busy_out), 32'(0));
    step();
  endtask

  task automatic check_idle_reset_values(input string tag);
    check({tag, "_tvalid"},  32'(tvalid_out),  32'(0));
    check({tag, "_tlast"},   32'(tlast_out),   32'(0));
    check({tag, "_tdata"},   32'(tdata_out),   32'(0));
    check({tag, "_rd_en"},   32'(rd_en_out),   32'(0));
    check({tag, "_rd_addr"}, 32'(rd_addr_out), 32'(0));
    check({tag, "_busy"},    32'(busy_out),    32'(0));
    check({tag, "_done"},    32'(done_out),    32'(0));
  endtask

  initial begin
    rst_n_in = 1'b0; start_in = 1'b0; base_addr_in = '0; frame_len_in = '0; tready_in = 1'b1;
    fill_mem();
    step(); step();
    rst_n_in = 1'b1;
    check_idle_reset_values("reset");

    run_frame(0, 5, 0, 0);           // basic frame
    run_frame(12, 4, 0, 0);          // address wrap 0xC,0xE,0x0,0x2
    run_frame(3, 6, 1, 0);           // backpressure pattern
    zero_len_start(7);
    run_frame(2, 6, 2, 1);           // start pulsed mid-frame is ignored
    run_frame(5, 15, 0, 0);          // longest frame
    run_frame(9, 1, 1, 0);           // single beat

    // Back-to-back: run_frame ends one cycle after done_out, so this start follows at once.
    run_frame(1, 3, 0, 0);
    run_frame(8, 2, 0, 0);

    // Reset mid-frame after the third beat handshakes.
    fill_mem();
    base_addr_in = 4'(6); frame_len_in = 4'(8); start_in = 1'b1; tready_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int cyc = 0; cyc < 50 && m_delivered < 3; cyc++) step();
    check("reset_after_beat3", 32'(m_delivered), 32'(3));
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    check_idle_reset_values("mid_reset");
    step(); step();
    check("no_done_after_reset", 32'(done_out), 32'(0));
    run_frame(10, 5, 0, 0);

    for (int n = 0; n < 20; n++) begin
      int len;
      fill_mem();
      len = int'($urandom_range(0, 15));
      if (len == 0) zero_len_start(int'($urandom_range(0, DEPTH - 1)));
      else run_frame(int'($urandom_range(0, DEPTH - 1)), len,
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
